// File: rtl/alu_exec.sv
// alu_exec: RV32I ALUreg/ALUimm execute stage for the multi-cycle core.
// Non-shift operations finish in one cycle. Shifts run serially, one bit
// per cycle, unless ALU_BARREL_SHIFT_EN is defined, in which case a
// combinational barrel shifter gives every operation a latency of one
// and the SHIFT state is never entered.
module alu_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_id,
    output logic        wb_en,
    output logic        illegal
);

    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_e;

    state_e      state_q, state_d;
    shift_e      shift_q, shift_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_id_q, rd_id_d;
    logic        done_q, done_d;
    logic        wb_en_q, wb_en_d;
    logic        illegal_q, illegal_d;

    // Decode of the live instruction; only consulted on the accepting edge.
    logic        is_reg;
    logic        is_legal;
    logic [2:0]  funct3;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic        is_shift;
    logic        rd_nonzero;
    shift_e      shift_kind;
    logic [31:0] alu_out;
    logic [31:0] acc_step;

    // rs1 index bits are consumed by the register bank, not by this stage.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[19:15];

    assign is_reg     = (instr[6:0] == OPC_REG);
    assign is_legal   = is_reg || (instr[6:0] == OPC_IMM);
    assign funct3     = instr[14:12];
    assign op2        = is_reg ? rs2 : {{20{instr[31]}}, instr[31:20]};
    assign shamt      = is_reg ? rs2[4:0] : instr[24:20];
    assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign rd_nonzero = (instr[11:7] != 5'd0);

`ifdef ALU_BARREL_SHIFT_EN
    function automatic logic [31:0] barrel(input logic [31:0] a, input logic [4:0] sh,
                                           input shift_e kind);
        logic [31:0] r;
        case (kind)
            SH_SLL:  r = a << sh;
            SH_SRA:  r = 32'($signed(a) >>> sh);
            default: r = a >> sh;
        endcase
        return r;
    endfunction
`endif

    // Shift direction/type selected by funct3 and instr[30].
    always_comb begin
        if (funct3 == 3'b001)
            shift_kind = SH_SLL;
        else if (instr[30])
            shift_kind = SH_SRA;
        else
            shift_kind = SH_SRL;
    end

    // Single-cycle result for every non-shift operation.
    always_comb begin
        case (funct3)
            3'b000:  alu_out = (is_reg && instr[30]) ? (rs1 - op2) : (rs1 + op2);
            3'b010:  alu_out = {31'd0, $signed(rs1) < $signed(op2)};
            3'b011:  alu_out = {31'd0, rs1 < op2};
            3'b100:  alu_out = rs1 ^ op2;
            3'b110:  alu_out = rs1 | op2;
            3'b111:  alu_out = rs1 & op2;
            default: alu_out = rs1;
        endcase
    end

    // One-bit step of the serial shifter; SRA replicates the sign bit.
    always_comb begin
        case (shift_q)
            SH_SLL:  acc_step = {acc_q[30:0], 1'b0};
            SH_SRA:  acc_step = {acc_q[31], acc_q[31:1]};
            default: acc_step = {1'b0, acc_q[31:1]};
        endcase
    end

    // State register and datapath flops, synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= SH_SLL;
            acc_q     <= 32'd0;
            cnt_q     <= 5'd0;
            result_q  <= 32'd0;
            rd_id_q   <= 5'd0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            rd_id_q   <= rd_id_d;
            done_q    <= done_d;
            wb_en_q   <= wb_en_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic: only a legal shift by a non-zero amount leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifndef ALU_BARREL_SHIFT_EN
                if (start && is_legal && is_shift && (shamt != 5'd0))
                    state_d = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                if (cnt_q == 5'd1)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and completion flags for the next cycle.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        shift_d   = shift_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        rd_id_d   = rd_id_q;
        done_d    = 1'b0;
        wb_en_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_id_d = instr[11:7];
                    done_d  = 1'b1;
                    if (!is_legal) begin
                        illegal_d = 1'b1;
                    end else if (is_shift) begin
`ifdef ALU_BARREL_SHIFT_EN
                        result_d = barrel(rs1, shamt, shift_kind);
                        wb_en_d  = rd_nonzero;
`else
                        if (shamt == 5'd0) begin
                            result_d = rs1;
                            wb_en_d  = rd_nonzero;
                        end else begin
                            acc_d   = rs1;
                            cnt_d   = shamt;
                            shift_d = shift_kind;
                            done_d  = 1'b0;
                        end
`endif
                    end else begin
                        result_d = alu_out;
                        wb_en_d  = rd_nonzero;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = acc_step;
                    done_d   = 1'b1;
                    wb_en_d  = (rd_id_q != 5'd0);
                end
            end
            default: ;
        endcase
    end

    // Output decode: busy is exactly the time spent in SHIFT.
    always_comb begin
        busy    = (state_q == S_SHIFT);
        done    = done_q;
        result  = result_q;
        rd_id   = rd_id_q;
        wb_en   = wb_en_q;
        illegal = illegal_q;
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases from the plan, then a
// randomized phase; a behavioural model predicts every output on every cycle.
module tb_alu_exec;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        busy, done, wb_en, illegal;
    logic [31:0] result;
    logic [4:0]  rd_id;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .instr  (instr_i),
        .rs1    (rs1_i),
        .rs2    (rs2_i),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_id  (rd_id),
        .wb_en  (wb_en),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_is_reg(input logic [31:0] i);
        return i[6:0] == 7'b0110011;
    endfunction

    function automatic bit ref_legal(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0010011);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] o2;
        int          sh;
        o2 = ref_is_reg(i) ? b : 32'($signed(i[31:20]));
        sh = int'(o2[4:0]);
        case (i[14:12])
            3'd0: return (ref_is_reg(i) && i[30]) ? a - o2 : a + o2;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
            3'd3: return (a < o2) ? 32'd1 : 32'd0;
            3'd4: return a ^ o2;
            3'd5: return i[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | o2;
            default: return a & o2;
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] i, input logic [31:0] b);
        int sh;
        sh = ref_is_reg(i) ? int'(b[4:0]) : int'(i[24:20]);
        if (!BARREL && (i[14:12] == 3'd1 || i[14:12] == 3'd5))
            return sh + 1;
        return 1;
    endfunction

    logic        model_valid = 1'b0;
    logic        e_busy = 1'b0, e_done = 1'b0, e_wb = 1'b0, e_ill = 1'b0;
    logic [31:0] e_res = 32'd0;
    logic [4:0]  e_rd = 5'd0;
    int          m_rem = 0;
    logic [31:0] m_pend = 32'd0;
    logic        m_pend_wb = 1'b0;

    // Model: remaining-cycles countdown per accepted op.
    always @(posedge clk) begin : model
        automatic int          rem;
        automatic int          lat;
        automatic logic        d, w, il;
        automatic logic [31:0] r, pend;
        automatic logic [4:0]  rd;
        automatic logic        pw;
        rem = m_rem; r = e_res; rd = e_rd; pend = m_pend; pw = m_pend_wb;
        d = 1'b0; w = 1'b0; il = 1'b0;
        if (rst) begin
            rem = 0; r = 32'd0; rd = 5'd0; pend = 32'd0; pw = 1'b0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                d = 1'b1; r = pend; w = pw;
            end
        end else if (start) begin
            rd = instr_i[11:7];
            if (!ref_legal(instr_i)) begin
                d = 1'b1; il = 1'b1;
            end else begin
                lat = ref_lat(instr_i, rs2_i);
                if (lat == 1) begin
                    d = 1'b1; r = ref_alu(instr_i, rs1_i, rs2_i); w = (rd != 5'd0);
                end else begin
                    rem = lat - 1;
                    pend = ref_alu(instr_i, rs1_i, rs2_i);
                    pw = (rd != 5'd0);
                end
            end
        end
        m_rem <= rem; m_pend <= pend; m_pend_wb <= pw;
        e_done <= d; e_wb <= w; e_ill <= il; e_res <= r; e_rd <= rd;
        e_busy <= (rem > 0);
        model_valid <= model_valid | rst;
    end

    // Compare process: every output, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_valid)
            check("cycle {busy,done,wb,ill,rd,result}",
                  64'({busy, done, wb_en, illegal, rd_id, result}),
                  64'({e_busy, e_done, e_wb, e_ill, e_rd, e_res}));
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input string name, input logic [31:0] i, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input int exp_busy, input logic exp_wb, input logic exp_ill,
                          input bit noise);
        int lat;
        int bcy;
        @(negedge clk);
        instr_i = i; rs1_i = a; rs2_i = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1; bcy = 0;
        while (!done && lat < 100) begin
            if (busy) bcy++;
            if (noise) begin
                start = 1'b1; instr_i = 32'h0000_1013 | ($urandom & 32'hFFFF_8F80);
                rs1_i = $urandom; rs2_i = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(bcy), 64'(exp_busy));
        check({name, " result"}, 64'(result), 64'(exp_res));
        check({name, " rd_id"}, 64'(rd_id), 64'(i[11:7]));
        check({name, " wb_en"}, 64'(wb_en), 64'(exp_wb));
        check({name, " illegal"}, 64'(illegal), 64'(exp_ill));
    endtask

    logic [31:0] i_sub, i_srai4, i_slli31;

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          pick;
        w = $urandom;
        pick = $urandom_range(0, 9);
        if (pick == 0) return w;
        if (pick < 5) begin
            w[6:0] = 7'b0110011;
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        end else begin
            w[6:0] = 7'b0010011;
        end
        return w;
    endfunction

    initial begin
        i_sub    = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        i_srai4  = {7'b0100000, 5'd4, 5'd1, 3'b101, 5'd5, 7'b0010011};
        i_slli31 = {7'b0000000, 5'd31, 5'd1, 3'b001, 5'd7, 7'b0010011};

        // Pin the model against hand-computed values.
        check("model sub", 64'(ref_alu(i_sub, 32'd5, 32'd7)), 64'hFFFF_FFFE);
        check("model srai4", 64'(ref_alu(i_srai4, 32'h8000_0000, 32'd0)), 64'hF800_0000);
        check("model slli31", 64'(ref_alu(i_slli31, 32'd1, 32'd0)), 64'h8000_0000);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset state", 64'({busy, done, wb_en, illegal, rd_id, result}), 64'd0);

        run_op("addi x1", {12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'd0, 32'd0,
               32'd1, 1, 0, 1'b1, 1'b0, 1'b0);
        run_op("sub", i_sub, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0, 1'b1, 1'b0, 1'b0);
        run_op("slt", {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0110011}, 32'hFFFF_FFFF, 32'd1,
               32'd1, 1, 0, 1'b1, 1'b0, 1'b0);
        run_op("sltu", {7'd0, 5'd2, 5'd1, 3'b011, 5'd4, 7'b0110011}, 32'hFFFF_FFFF, 32'd1,
               32'd0, 1, 0, 1'b1, 1'b0, 1'b0);
        run_op("srai 4", i_srai4, 32'h8000_0000, 32'd0, 32'hF800_0000,
               BARREL ? 1 : 5, BARREL ? 0 : 4, 1'b1, 1'b0, 1'b0);
        run_op("srli 0", {7'd0, 5'd0, 5'd1, 3'b101, 5'd6, 7'b0010011}, 32'h1234_5678, 32'd0,
               32'h1234_5678, 1, 0, 1'b1, 1'b0, 1'b0);
        run_op("add x0", {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011}, 32'd3, 32'd4,
               32'd7, 1, 0, 1'b0, 1'b0, 1'b0);
        run_op("ebreak", 32'h0010_0073, 32'd9, 32'd9, 32'd7, 1, 0, 1'b0, 1'b1, 1'b0);
        run_op("slli 31 with noise", i_slli31, 32'd1, 32'd0, 32'h8000_0000,
               BARREL ? 1 : 32, BARREL ? 0 : 31, 1'b1, 1'b0, 1'b1);
        run_op("srli 31", {7'd0, 5'd31, 5'd1, 3'b101, 5'd8, 7'b0010011}, 32'h8000_0000, 32'd0,
               32'd1, BARREL ? 1 : 32, BARREL ? 0 : 31, 1'b1, 1'b0, 1'b0);

        // Reset during shift cycle 3 aborts with no done pulse.
        @(negedge clk);
        instr_i = {7'd0, 5'd10, 5'd1, 3'b001, 5'd9, 7'b0010011}; rs1_i = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst mid-shift", 64'({busy, done, wb_en, illegal, rd_id, result}), 64'd0);

        // Reset together with start: nothing is accepted.
        instr_i = {12'd5, 5'd0, 3'b000, 5'd2, 7'b0010011}; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst with start", 64'({busy, done, result}), 64'd0);

        // Randomized phase, including back-to-back issue and rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 2) == 0);
            instr_i = gen_instr();
            rs1_i   = $urandom;
            rs2_i   = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
